// File: rtl/sync_debounce_pkg.sv
// Shared types and elaboration helpers for the sync_debounce block.
package sync_debounce_pkg;

    // Stability-check FSM states; encodings kept from the original header.
    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_CHK_HI  = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_CHK_LO  = 2'd3
    } state_e;

    // HOLD must need at least two samples and stay representable by the counter.
    function automatic bit hold_ok(input int hold, input int cnt_w);
        return (hold >= 2) && (hold <= (1 << cnt_w));
    endfunction

    // Synchronizer depth is limited to a sensible metastability range.
    function automatic bit stages_ok(input int stages);
        return (stages >= 2) && (stages <= 4);
    endfunction

endpackage

// File: rtl/sync_debounce_chain.sv
// SYNC_STAGES-deep flop chain bringing an asynchronous level into the clock domain.
module sync_chain
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (!stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES must be in 2..4");
    end

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    // Shift the raw input in at stage 0; the oldest sample leaves at the top.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    // Chain registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Debouncer: synchronizer chain followed by a HOLD-edge stability-check FSM
// producing a debounced level plus one-cycle rise/fall pulses.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 4,
    parameter int CNT_W       = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (!hold_ok(HOLD, CNT_W)) begin : g_bad_hold
        $error("sync_debounce: HOLD must be in 2..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic s;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (d),
        .q    (s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             busy_q,  busy_d;

    // Next-state, counter and pulse decode for the stability check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE_LO: begin
                if (en && s) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_IDLE_HI: begin
                if (en && !s) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHK_HI: begin
                if (!en || !s) begin
                    state_d = ST_IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_CHK_LO: begin
                if (!en || s) begin
                    state_d = ST_IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_CHK_HI) || (state_d == ST_CHK_LO);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Single-clock conditioner for one asynchronous level input. An N-stage synchronizer chain feeds a stability-check FSM. The FSM updates the output level only after the synchronized input has held a new value for HOLD consecutive clock edges. Bounces and sub-period glitches are rejected, and the block emits one-cycle rise/fall pulses for downstream control logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4)
HOLD, 4, consecutive sampled edges required to accept a new level (legal range 2..2**CNT_W)
CNT_W, 4, stability counter width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
d      input  1  asynchronous raw level input
en     input  1  check enable; low aborts and blocks level changes
dout   output 1  debounced level
rise   output 1  one-cycle pulse when dout goes 0->1
fall   output 1  one-cycle pulse when dout goes 1->0
busy   output 1  high while a stability check is in progress

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high, sampled on the rising edge of clock. While reset=1 at an edge, all of the following are 0 after that edge: synchronizer flops, cnt, dout, rise, fall, busy. State becomes IDLE_LO.
- Synchronizer: d passes through SYNC_STAGES flops. s is the last-stage output. Nothing else samples d.
- States: IDLE_LO (dout=0), CHK_HI, IDLE_HI (dout=1), CHK_LO. busy=1 exactly in CHK_HI and CHK_LO. All outputs are registered.
- IDLE_x, with en=1 and s!=dout: go to CHK_y and set cnt<=1.
- IDLE_x, otherwise: stay, cnt=0.
- CHK_y, en=0 or s==dout (bounce): return to IDLE_x, cnt<=0. dout unchanged, no pulse.
- CHK_y, s!=dout and cnt<HOLD-1: cnt<=cnt+1.
- CHK_y, s!=dout and cnt==HOLD-1: toggle dout, go to IDLE of the new level, cnt<=0. Assert rise (new dout=1) or fall (new dout=0) for exactly one cycle.
- Latency: d stable from before edge n gives s valid at edge n+SYNC_STAGES-1, and dout changes at edge n+SYNC_STAGES+HOLD-1 (n+5 with defaults). busy rises at edge n+SYNC_STAGES.
- Counter: no wrap is possible because cnt never exceeds HOLD-1. Elaboration fails (generate-time error) if HOLD>2**CNT_W or HOLD<2.
- rise and fall are never high together. Neither is high in the cycle after reset.
- en low: the synchronizer keeps running and the FSM parks in IDLE. When en returns high, a check restarts from cnt=1 on the next edge where s!=dout.
- Reset mid-check: the count is discarded and no pulse is emitted. After release, the full latency applies again.
- Glitch shorter than one clock period that misses every sampling edge: no effect. A glitch caught by a single edge: the check aborts at most HOLD edges later, dout unchanged.

Decomposition:
- Shared header sync_debounce_defs.vh holds the state encoding localparams (ST_IDLE_LO=2'd0, ST_CHK_HI=2'd1, ST_IDLE_HI=2'd2, ST_CHK_LO=2'd3) and the HOLD range-check macro.
- One sub-module, sync_chain: parameterized SYNC_STAGES flop chain with synchronous reset, ports clock, reset, d, q.
- FSM, counter and pulse logic stay in sync_debounce.

Test Plan:
Defaults throughout, 40 ns clock period.
- Reset held 3 edges with d=1, then released with d=0 -> dout=0, rise=0, fall=0, busy=0 for 10 edges.
- d 0->1 set 5 ns before edge n and held -> busy=1 from edge n+2; dout=1 and rise=1 at edge n+5; rise=0 at n+6; busy=0 at n+5.
- d high for 2 edges only (n, n+1), then 0 -> busy high for 2 cycles; dout stays 0; rise never asserted.
- d pulses of 2 ns, 3 ns and 5 ns placed between edges -> busy, dout, rise and fall all constant.
- From dout=1, d 1->0 held -> fall=1 and dout=0 at edge n+5. Then en=0 during a new rising check at cnt=2 -> busy drops next edge, dout stays 0.
- Reset asserted at cnt=3 in CHK_HI -> next edge all outputs 0 and no rise pulse. After release with d=1 held, rise occurs exactly SYNC_STAGES+HOLD-1 edges after the first post-reset sampling edge.
